// File: rtl/vproc_vregfile_mp.sv
// Multi-ported vector register file: one write-port bank per write port, stored word = XOR of all banks.
// Registered write-first reads, lower-port-wins byte conflict masking, and a zeroing sequencer after reset/clear.
module vproc_vregfile_mp #(
  parameter int VREG_CNT = 32,
  parameter int VREG_W   = 128,
  parameter int PORT_W   = 64,
  parameter int PORTS_RD = 2,
  parameter int PORTS_WR = 2,
  localparam int WORDS   = VREG_CNT * VREG_W / PORT_W,
  localparam int ADDR_W  = $clog2(WORDS),
  localparam int BE_W    = PORT_W / 8
) (
  input  logic              clk_i,
  input  logic              sync_rst_i,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] wr_addr_i [PORTS_WR],
  input  logic [PORT_W-1:0] wr_data_i [PORTS_WR],
  input  logic [BE_W-1:0]   wr_be_i   [PORTS_WR],
  input  logic              wr_we_i   [PORTS_WR],
  output logic              wr_conflict_o,
  input  logic [ADDR_W-1:0] rd_addr_i [PORTS_RD],
  output logic [PORT_W-1:0] rd_data_o [PORTS_RD]
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               busy;

  logic [PORT_W-1:0]  mem     [PORTS_WR][WORDS];
  logic [BE_W-1:0]    be_m    [PORTS_WR];
  logic [PORT_W-1:0]  others  [PORTS_WR];
  logic [PORT_W-1:0]  rd_word [PORTS_RD];
  logic [PORT_W-1:0]  rd_q    [PORTS_RD];
  logic               conflict, conflict_q;

  assign busy   = (state_q == CLEAR);
  assign busy_o = busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) state_d = READY;
      end
      READY: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A higher-priority port on the same word strips its bytes from every later port.
  always_comb begin
    conflict = 1'b0;
    for (int w = 0; w < PORTS_WR; w++) begin
      be_m[w] = (wr_we_i[w] && !busy) ? wr_be_i[w] : '0;
      for (int v = 0; v < w; v++) begin
        if (wr_we_i[v] && !busy && (wr_addr_i[v] == wr_addr_i[w])) begin
          if ((wr_be_i[v] & be_m[w]) != '0) conflict = 1'b1;
          be_m[w] = be_m[w] & ~wr_be_i[v];
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < PORTS_WR; w++) begin
      others[w] = '0;
      for (int v = 0; v < PORTS_WR; v++)
        if (v != w) others[w] = others[w] ^ mem[v][wr_addr_i[w]];
    end
  end

  always_comb begin
    for (int r = 0; r < PORTS_RD; r++) begin
      rd_word[r] = '0;
      for (int v = 0; v < PORTS_WR; v++)
        rd_word[r] = rd_word[r] ^ mem[v][rd_addr_i[r]];
      for (int w = 0; w < PORTS_WR; w++)
        for (int b = 0; b < BE_W; b++)
          if (be_m[w][b] && (wr_addr_i[w] == rd_addr_i[r]))
            rd_word[r][b*8 +: 8] = wr_data_i[w][b*8 +: 8];
    end
  end

  // Banks are not reset; the clear sequencer zeroes them word by word instead.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      for (int w = 0; w < PORTS_WR; w++) begin
        if (busy) begin
          mem[w][cnt_q] <= '0;
        end else begin
          for (int b = 0; b < BE_W; b++)
            if (be_m[w][b])
              mem[w][wr_addr_i[w]][b*8 +: 8] <= wr_data_i[w][b*8 +: 8] ^ others[w][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      for (int r = 0; r < PORTS_RD; r++) rd_q[r] <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < PORTS_RD; r++) rd_q[r] <= busy ? '0 : rd_word[r];
      conflict_q <= conflict;
    end
  end

  always_comb begin
    for (int r = 0; r < PORTS_RD; r++) rd_data_o[r] = busy ? '0 : rd_q[r];
    wr_conflict_o = conflict_q && !busy;
  end

endmodule

// File: tb/tb_vproc_vregfile_mp.sv
// Randomized self-checking bench for vproc_vregfile_mp against a byte-level reference memory.
module tb_vproc_vregfile_mp;

  localparam int WORDS  = 64;
  localparam int ADDR_W = 6;
  localparam int PORT_W = 64;
  localparam int BE_W   = 8;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              busy;
  logic [ADDR_W-1:0] wr_addr [2];
  logic [PORT_W-1:0] wr_data [2];
  logic [BE_W-1:0]   wr_be   [2];
  logic              wr_we   [2];
  logic              wr_conflict;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [PORT_W-1:0] rd_data [2];

  int passed = 0;
  int total  = 0;

  logic [PORT_W-1:0] ref_mem [WORDS];
  int                clear_left;
  logic [PORT_W-1:0] exp_rd [2];
  logic              exp_conf;

  vproc_vregfile_mp #(
    .VREG_CNT(32), .VREG_W(128), .PORT_W(64), .PORTS_RD(2), .PORTS_WR(2)
  ) dut (
    .clk_i        (clk),
    .sync_rst_i   (rst),
    .clear_i      (clear),
    .busy_o       (busy),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_be_i      (wr_be),
    .wr_we_i      (wr_we),
    .wr_conflict_o(wr_conflict),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference behaviour for one rising edge, using the inputs currently driven.
  task automatic modelEdge();
    if (rst) begin
      clear_left = WORDS;
      exp_conf   = 1'b0;
      exp_rd[0]  = '0;
      exp_rd[1]  = '0;
    end else if (clear_left > 0) begin
      ref_mem[WORDS - clear_left] = '0;
      clear_left--;
      exp_conf  = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      exp_conf = wr_we[0] && wr_we[1] && (wr_addr[0] == wr_addr[1]) && ((wr_be[0] & wr_be[1]) != 0);
      for (int p = 1; p >= 0; p--)
        if (wr_we[p])
          for (int b = 0; b < BE_W; b++)
            if (wr_be[p][b]) ref_mem[wr_addr[p]][b*8 +: 8] = wr_data[p][b*8 +: 8];
      exp_rd[0] = ref_mem[rd_addr[0]];
      exp_rd[1] = ref_mem[rd_addr[1]];
      if (clear) clear_left = WORDS;
    end
  endtask

  task automatic applyStimulus();
    logic exp_busy;
    @(posedge clk);
    modelEdge();
    #1;
    exp_busy = (clear_left > 0);
    checkOutput("busy", {63'd0, busy}, {63'd0, exp_busy});
    checkOutput("conflict", {63'd0, wr_conflict}, {63'd0, exp_busy ? 1'b0 : exp_conf});
    checkOutput("rd0", rd_data[0], exp_busy ? 64'd0 : exp_rd[0]);
    checkOutput("rd1", rd_data[1], exp_busy ? 64'd0 : exp_rd[1]);
  endtask

  task automatic setIdle();
    clear      = 1'b0;
    wr_we[0]   = 1'b0;
    wr_we[1]   = 1'b0;
    wr_be[0]   = '0;
    wr_be[1]   = '0;
    wr_addr[0] = '0;
    wr_addr[1] = '0;
    wr_data[0] = '0;
    wr_data[1] = '0;
    rd_addr[0] = ADDR_W'($urandom_range(0, WORDS - 1));
    rd_addr[1] = ADDR_W'($urandom_range(0, WORDS - 1));
  endtask

  task automatic setRandom(input logic allow_clear);
    for (int p = 0; p < 2; p++) begin
      wr_we[p]   = ($urandom_range(0, 3) != 0);
      wr_addr[p] = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7))
                                               : ADDR_W'($urandom_range(0, WORDS - 1));
      wr_data[p] = {$urandom, $urandom};
      wr_be[p]   = 8'($urandom);
      rd_addr[p] = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7))
                                               : ADDR_W'($urandom_range(0, WORDS - 1));
    end
    clear = allow_clear && ($urandom_range(0, 99) == 0);
  endtask

  task automatic measureBusy(input string tag);
    int n = 0;
    setIdle();
    while (busy && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 64'(n), 64'(WORDS));
  endtask

  task automatic readAll();
    for (int i = 0; i < WORDS; i++) begin
      setIdle();
      rd_addr[0] = ADDR_W'(i);
      rd_addr[1] = ADDR_W'(WORDS - 1 - i);
      applyStimulus();
    end
    setIdle();
    applyStimulus();
  endtask

  task automatic writeWord(input int port, input int addr, input logic [63:0] data, input logic [7:0] be);
    wr_we[port]   = 1'b1;
    wr_addr[port] = ADDR_W'(addr);
    wr_data[port] = data;
    wr_be[port]   = be;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    clear_left = WORDS;
    exp_conf   = 1'b0;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
    setIdle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    rst = 1'b0;
    measureBusy("busy_len_reset");
    readAll();

    setIdle();
    writeWord(0, 5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    writeWord(1, 9, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    applyStimulus();
    setIdle();
    rd_addr[0] = 6'd5;
    rd_addr[1] = 6'd9;
    applyStimulus();
    checkOutput("par_wr0", rd_data[0], 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("par_wr1", rd_data[1], 64'h1234_5678_9ABC_DEF0);

    setIdle();
    writeWord(0, 3, 64'h1111_1111_1111_1111, 8'hFF);
    applyStimulus();
    setIdle();
    writeWord(1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd_addr[0] = 6'd3;
    applyStimulus();
    checkOutput("wf_partial", rd_data[0], 64'h1111_1111_FFFF_FFFF);

    setIdle();
    writeWord(0, 7, 64'h0, 8'hFF);
    writeWord(1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    rd_addr[0] = 6'd7;
    applyStimulus();
    checkOutput("conf_flag", {63'd0, wr_conflict}, 64'd1);
    checkOutput("conf_word", rd_data[0], 64'h0);
    setIdle();
    writeWord(0, 7, 64'h0, 8'h0F);
    writeWord(1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    rd_addr[1] = 6'd7;
    applyStimulus();
    checkOutput("disjoint_flag", {63'd0, wr_conflict}, 64'd0);
    checkOutput("disjoint_word", rd_data[1], 64'hFFFF_FFFF_0000_0000);

    for (int i = 0; i < 600; i++) begin
      setRandom(1'b1);
      applyStimulus();
    end
    setIdle();
    while (busy && clear_left > 0) applyStimulus();

    for (int i = 0; i < WORDS; i += 2) begin
      setIdle();
      writeWord(0, i, {$urandom, $urandom} | 64'd1, 8'hFF);
      writeWord(1, i + 1, {$urandom, $urandom} | 64'd1, 8'hFF);
      applyStimulus();
    end
    setIdle();
    clear = 1'b1;
    applyStimulus();
    for (int i = 0; i < 30; i++) begin
      setRandom(1'b1);
      applyStimulus();
    end
    for (int i = 0; i < 40 && busy; i++) begin
      setIdle();
      applyStimulus();
    end
    readAll();

    setIdle();
    clear = 1'b1;
    applyStimulus();
    for (int i = 0; i < 20; i++) begin
      setIdle();
      applyStimulus();
    end
    setRandom(1'b0);
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    measureBusy("busy_len_midclear");
    readAll();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vproc_vregfile_mp.md
# vproc_vregfile_mp

Parametrised multi-ported vector register file for the vector core, built from one-write-port RAM banks combined by XOR so that all write ports commit in parallel. Generalises the register file in register count, port width and port counts. Adds a registered, write-first read path, same-address write-conflict resolution, and a clear sequencer that zeroes every register after reset or on request. Sits between the vector pipelines' operand fetch and result write-back stages.

## Interface
- VREG_CNT, 32: number of vector registers (power of two, ≥2)
- VREG_W, 128: vector register width in bits
- PORT_W, 64: port width in bits; VREG_W/PORT_W is a power of two; PORT_W multiple of 8
- PORTS_RD, 2: read ports (≥1)
- PORTS_WR, 2: write ports (≥1)
- Derived: WORDS = VREG_CNT·VREG_W/PORT_W; ADDR_W = $clog2(WORDS); word address = {reg index, sub-word index}
- clk_i  in  1  clock; all logic on rising edge
- sync_rst_i  in  1  synchronous active-high reset
- clear_i  in  1  pulse: start zeroing all registers
- busy_o  out  1  clear in progress; writes ignored, reads return 0
- wr_addr_i[PORTS_WR]  in  ADDR_W  write word address
- wr_data_i[PORTS_WR]  in  PORT_W  write data
- wr_be_i[PORTS_WR]  in  PORT_W/8  byte enables
- wr_we_i[PORTS_WR]  in  1  write enable
- wr_conflict_o  out  1  one-cycle pulse: overlapping same-address write resolved in previous cycle
- rd_addr_i[PORTS_RD]  in  ADDR_W  read word address
- rd_data_o[PORTS_RD]  out  PORT_W  registered read data

## Operation
- Storage: PORTS_WR banks; bank w has PORTS_RD external plus PORTS_WR−1 internal read ports. Stored value of a word = XOR of that word across all banks. Bank w is written with (new data) XOR (same word in every other bank), per enabled byte.
- Write conflict: ports i<j, equal addresses, both we, overlapping be → overlapping bytes of port j masked (lower index wins); non-overlapping bytes from both commit. wr_conflict_o = 1 in the following cycle. Equal addresses, disjoint be: both commit, no flag.
- Read: rd_data_o[r] updates each cycle to the word at rd_addr_i[r] sampled at the previous edge. Write-first: bytes written in that same cycle (after conflict masking) appear in the returned data.
- Clear FSM, states CLEAR and READY:
  - sync_rst_i = 1 → CLEAR, counter = 0.
  - CLEAR: zero counter word in all banks (all bytes); counter += 1; at counter = WORDS−1 → READY next edge.
  - READY: clear_i = 1 → CLEAR, counter = 0. No other exit.
  - clear_i during CLEAR ignored (no restart).
  - busy_o = 1 iff state = CLEAR.
- While busy_o: wr_we_i ignored, rd_data_o driven 0, wr_conflict_o 0.

## Timing
- Reset values: rd_data_o = 0 (all ports), busy_o = 1, wr_conflict_o = 0, state CLEAR, counter 0.
- Clear: first edge after reset release clears word 0; busy_o falls after exactly WORDS edges; first write accepted in that cycle. clear_i in READY → busy_o high next cycle for WORDS cycles.
- Read latency 1 cycle; write visible to any read port in the same cycle (write-first) and thereafter.
- wr_conflict_o latency 1 cycle, width 1 cycle per conflicting cycle.
- Reset mid-clear or mid-write: clear restarts at word 0; in-flight write discarded.
- Address wrap: none; addresses ≥ WORDS unreachable by construction (WORDS is a power of two).

## Test plan
- Reset/clear: VREG_CNT=32, VREG_W=128, PORT_W=64 (WORDS=64); release reset → busy_o high 64 cycles; then read all 64 words on both ports → all 0x0.
- Parallel writes: WP0 addr 5 = 0xAAAA_AAAA_AAAA_AAAA, WP1 addr 9 = 0x1234_5678_9ABC_DEF0, be=0xFF → next cycle reads of 5/9 on RP0/RP1 return those values; flag 0.
- Write-first/partial: word 3 = 0x1111_1111_1111_1111; then WP1 addr 3 be=0x0F data 0xFFFF_FFFF_FFFF_FFFF with RP0 addr 3 same cycle → rd_data_o[0] = 0x1111_1111_FFFF_FFFF next cycle.
- Conflict: WP0 and WP1 both addr 7, be 0xFF / 0xF0, data 0x0 / all ones → word 7 = 0x0, wr_conflict_o = 1 for one cycle; with WP1 be 0xF0, WP0 be 0x0F, data ones/zero → 0xFFFF_FFFF_0000_0000... (WP1 upper ones) = 0xFFFF_FFFF_0000_0000, flag 0.
- Runtime clear: fill words 0–63 with nonzero data; pulse clear_i; writes during busy ignored, reads return 0; after 64 cycles all words 0.
- Reset mid-clear: assert sync_rst_i at clear counter 20 → busy_o stays high, full 64-cycle clear after release, all words 0.
